tea_io_mailbox: RTL and testbench
=================================

Name: tea_io_mailbox

Overview:
- IO-mapped byte mailbox on the tea_cpu IO bus (io_addr/io_rd/io_wr/io_rddata/io_wrdata).
- Carries byte streams between an external host and the CPU:
  - RX FIFO: host to CPU.
  - TX FIFO: CPU to host.
- Also provides sticky error flags and a done pulse, so TEA key/data bytes can be streamed in and results streamed out.
- Sits directly downstream of the CPU's IO port.

Parameters:
- FIFO_AW, 3, log2 of each FIFO depth (default depth 8).
- DATA_W, 8, byte width; fixed to match the CPU accumulator.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- io_addr  in  5  register select from CPU.
- io_rd  in  1  CPU read strobe.
- io_wr  in  1  CPU write strobe.
- io_wrdata  in  8  CPU write data (accumulator).
- io_rddata  out  8  read data to CPU.
- s_valid  in  1  host RX byte valid.
- s_ready  out  1  RX FIFO can accept.
- s_data  in  8  host RX byte.
- m_valid  out  1  TX FIFO head valid.
- m_ready  in  1  host accepts TX byte.
- m_data  out  8  TX FIFO head byte.
- done  out  1  one-cycle pulse when CPU writes CTRL.bit0.

Behaviour:
- Strobe commit rule:
  - The CPU holds io_rd/io_wr high for exactly two clocks per access.
  - An access commits on the clock edge where the strobe is high and was also high in the previous cycle (registered io_rd_d/io_wr_d).
  - Each strobe run commits at most once (committed flag cleared when the strobe drops).
  - A single-cycle strobe never commits.
- io_rddata:
  - Combinational from io_addr while io_rd=1; 0x00 while io_rd=0.
  - Must be stable across both strobe cycles; the FIFO head changes only at the commit edge.
- Register map:
  - 0x00 RX_DATA, read:
    - Returns the RX head and pops it at commit.
    - If RX is empty: returns 0x00, no pop, sets rx_unf.
  - 0x01 TX_DATA, write:
    - Pushes io_wrdata at commit.
    - If TX is full: byte dropped, sets tx_ovf.
  - 0x02 STATUS:
    - Read: {3'b0, loop, tx_ovf, rx_unf, tx_full, rx_nonempty}.
    - Write: 1 in bit2 clears rx_unf; 1 in bit3 clears tx_ovf.
  - 0x03 RX_COUNT, read: number of bytes held in RX (0..2^FIFO_AW), zero-extended.
  - 0x04 CTRL, write:
    - bit0=1 drives done high for exactly one cycle, the cycle after commit.
    - bit1 = loop (see Optional Feature).
  - Any other address: reads 0x00, writes ignored.
- FIFOs:
  - Circular buffers, pointer width FIFO_AW+1; full/empty derived from MSB compare.
  - s_ready = !rx_full.
  - Host push when s_valid && s_ready.
  - m_valid = !tx_empty; m_data = TX head; host pop when m_valid && m_ready.
  - No bypass: a byte pushed into an empty FIFO becomes visible the next cycle.
  - Simultaneous push and pop on one FIFO: both occur, count unchanged, pointers each advance by 1.
  - Pop when full frees a slot for the next cycle only; s_ready does not rise in the same cycle.
  - Pointers wrap modulo 2^(FIFO_AW+1).
- Sticky flags: set-over-clear priority when set and clear coincide in the same cycle.
- Reset (async assert, sync-safe deassert):
  - Pointers 0; flags 0; loop 0; done 0; io_rd_d/io_wr_d 0.
  - Resulting outputs: s_ready=1, m_valid=0, m_data=0x00 (head of cleared storage masked to 0 when empty), io_rddata=0x00.
- Reset mid-operation: all FIFO contents are discarded; an in-flight strobe run does not commit after reset releases unless two fresh high cycles are seen.

Optional Feature:
- Macro: TEA_MAILBOX_LOOPBACK_EN.
- Defined:
  - CTRL.bit1 sets loop.
  - While loop=1, committed TX_DATA writes are pushed into RX instead of TX; overflow sets tx_ovf.
  - Host s_valid pushes still have priority that cycle; the CPU write is dropped with tx_ovf set.
  - s_ready = !rx_full && !loop.
- Undefined: CTRL.bit1 is ignored, and STATUS.bit4 reads 0.

Test Plan:
- Reset, then host pushes 0x9E,0x37,0x79,0xB9 -> RX_COUNT reads 0x04; four RX_DATA reads return 0x9E,0x37,0x79,0xB9 in order; STATUS=0x00 afterwards.
- RX_DATA read with RX empty -> io_rddata=0x00, STATUS=0x04; write STATUS 0x04 -> STATUS=0x00.
- CPU writes 9 bytes 0x01..0x09 with m_ready=0 -> m_valid=1; STATUS=0x0A (tx_full, tx_ovf); host drains exactly 0x01..0x08.
- Host push and CPU RX_DATA commit on the same edge with RX holding 3 bytes -> RX_COUNT stays 0x03, order preserved; 1-cycle io_rd pulse -> no pop.
- Write CTRL 0x01 -> done high exactly one cycle; assert rst mid-stream with 5 bytes queued -> s_ready=1, m_valid=0, RX_COUNT=0x00 immediately.
- With TEA_MAILBOX_LOOPBACK_EN: CTRL 0x02, write TX_DATA 0xC6 -> RX_DATA reads 0xC6, m_valid stays 0, s_ready=0.

Source files
------------

// File: rtl/tea_io_mailbox_if.sv
// Bus bundle for tea_io_mailbox: CPU IO-port strobes plus the host RX/TX byte streams.
// The master side is the CPU/host driver; the slave side is the mailbox.
interface tea_io_mailbox_if #(
    parameter int DATA_W = 8
);
    logic [4:0]        io_addr;
    logic              io_rd;
    logic              io_wr;
    logic [DATA_W-1:0] io_wrdata;
    logic [DATA_W-1:0] io_rddata;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              done;

    modport master (
        output io_addr, io_rd, io_wr, io_wrdata, s_valid, s_data, m_ready,
        input  io_rddata, s_ready, m_valid, m_data, done
    );

    modport slave (
        input  io_addr, io_rd, io_wr, io_wrdata, s_valid, s_data, m_ready,
        output io_rddata, s_ready, m_valid, m_data, done
    );
endinterface

// File: rtl/tea_io_mailbox.sv
// IO-mapped byte mailbox: RX FIFO (host->CPU), TX FIFO (CPU->host), sticky error flags, done pulse.
// Optional CPU->RX loopback is enabled by defining TEA_MAILBOX_LOOPBACK_EN.
module tea_io_mailbox #(
    parameter int FIFO_AW = 3,
    parameter int DATA_W  = 8
) (
    input logic              clk,
    input logic              rst,
    tea_io_mailbox_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;
    localparam logic [4:0] ADDR_RX   = 5'h00;
    localparam logic [4:0] ADDR_TX   = 5'h01;
    localparam logic [4:0] ADDR_STAT = 5'h02;
    localparam logic [4:0] ADDR_CNT  = 5'h03;
    localparam logic [4:0] ADDR_CTRL = 5'h04;

    logic [DATA_W-1:0] rx_mem_q [DEPTH];
    logic [DATA_W-1:0] tx_mem_q [DEPTH];
    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic io_rd_q, io_wr_q, rd_done_q, rd_done_d, wr_done_q, wr_done_d;
    logic rx_unf_q, rx_unf_d, tx_ovf_q, tx_ovf_d, done_q, done_d;
    logic loop_s;

    logic rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic rd_commit_s, wr_commit_s, host_push_s, rx_pop_s, unf_set_s;
    logic tx_wr_s, lb_push_s, tx_push_s, tx_pop_s, ovf_set_s, rx_push_s;
    logic stat_wr_s, ctrl_wr_s;
    logic [DATA_W-1:0] rx_push_data_s, rd_data_s;
    logic [PW-1:0] rx_count_s;

    assign rx_empty_s = (rx_wp_q == rx_rp_q);
    assign rx_full_s  = (rx_wp_q[FIFO_AW] != rx_rp_q[FIFO_AW]) &&
                        (rx_wp_q[FIFO_AW-1:0] == rx_rp_q[FIFO_AW-1:0]);
    assign tx_empty_s = (tx_wp_q == tx_rp_q);
    assign tx_full_s  = (tx_wp_q[FIFO_AW] != tx_rp_q[FIFO_AW]) &&
                        (tx_wp_q[FIFO_AW-1:0] == tx_rp_q[FIFO_AW-1:0]);
    assign rx_count_s = rx_wp_q - rx_rp_q;

    // A strobe commits on its second consecutive high cycle, once per run.
    assign rd_commit_s = bus.io_rd && io_rd_q && !rd_done_q;
    assign wr_commit_s = bus.io_wr && io_wr_q && !wr_done_q;

    assign host_push_s    = bus.s_valid && bus.s_ready;
    assign rx_pop_s       = rd_commit_s && (bus.io_addr == ADDR_RX) && !rx_empty_s;
    assign unf_set_s      = rd_commit_s && (bus.io_addr == ADDR_RX) && rx_empty_s;
    assign tx_wr_s        = wr_commit_s && (bus.io_addr == ADDR_TX);
    assign lb_push_s      = tx_wr_s && loop_s && !host_push_s && !rx_full_s;
    assign tx_push_s      = tx_wr_s && !loop_s && !tx_full_s;
    assign ovf_set_s      = tx_wr_s && !(lb_push_s || tx_push_s);
    assign rx_push_s      = host_push_s || lb_push_s;
    assign rx_push_data_s = host_push_s ? bus.s_data : bus.io_wrdata;
    assign tx_pop_s       = !tx_empty_s && bus.m_ready;
    assign stat_wr_s      = wr_commit_s && (bus.io_addr == ADDR_STAT);
    assign ctrl_wr_s      = wr_commit_s && (bus.io_addr == ADDR_CTRL);

`ifdef TEA_MAILBOX_LOOPBACK_EN
    logic loop_q;
    // Loopback mode register, written through CTRL.bit1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loop_q <= 1'b0;
        end else if (ctrl_wr_s) begin
            loop_q <= bus.io_wrdata[1];
        end
    end
    assign loop_s = loop_q;
`else
    assign loop_s = 1'b0;
`endif

    // Next-state for pointers, commit tracking and sticky flags (set wins over clear).
    always_comb begin
        rx_wp_d   = rx_wp_q + {{(PW-1){1'b0}}, rx_push_s};
        rx_rp_d   = rx_rp_q + {{(PW-1){1'b0}}, rx_pop_s};
        tx_wp_d   = tx_wp_q + {{(PW-1){1'b0}}, tx_push_s};
        tx_rp_d   = tx_rp_q + {{(PW-1){1'b0}}, tx_pop_s};
        rd_done_d = bus.io_rd ? (rd_done_q || rd_commit_s) : 1'b0;
        wr_done_d = bus.io_wr ? (wr_done_q || wr_commit_s) : 1'b0;
        rx_unf_d  = unf_set_s || (rx_unf_q && !(stat_wr_s && bus.io_wrdata[2]));
        tx_ovf_d  = ovf_set_s || (tx_ovf_q && !(stat_wr_s && bus.io_wrdata[3]));
        done_d    = ctrl_wr_s && bus.io_wrdata[0];
    end

    // Control state; storage below is deliberately left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wp_q   <= {PW{1'b0}};
            rx_rp_q   <= {PW{1'b0}};
            tx_wp_q   <= {PW{1'b0}};
            tx_rp_q   <= {PW{1'b0}};
            io_rd_q   <= 1'b0;
            io_wr_q   <= 1'b0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            rx_unf_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            io_rd_q   <= bus.io_rd;
            io_wr_q   <= bus.io_wr;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
            rx_unf_q  <= rx_unf_d;
            tx_ovf_q  <= tx_ovf_d;
            done_q    <= done_d;
        end
    end

    // FIFO storage writes.
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_q[rx_wp_q[FIFO_AW-1:0]] <= rx_push_data_s;
        end
        if (tx_push_s) begin
            tx_mem_q[tx_wp_q[FIFO_AW-1:0]] <= bus.io_wrdata;
        end
    end

    // Read mux; the RX head only moves at the commit edge, so data is stable for the whole strobe.
    always_comb begin
        rd_data_s = {DATA_W{1'b0}};
        if (bus.io_rd) begin
            case (bus.io_addr)
                ADDR_RX:   rd_data_s = rx_empty_s ? {DATA_W{1'b0}} : rx_mem_q[rx_rp_q[FIFO_AW-1:0]];
                ADDR_STAT: rd_data_s = {3'b000, loop_s, tx_ovf_q, rx_unf_q, tx_full_s, !rx_empty_s};
                ADDR_CNT:  rd_data_s = {{(DATA_W-PW){1'b0}}, rx_count_s};
                default:   rd_data_s = {DATA_W{1'b0}};
            endcase
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    assign bus.io_rddata = rd_data_s;
    assign bus.s_ready   = !rx_full_s && !loop_s;
    assign bus.m_valid   = !tx_empty_s;
    assign bus.m_data    = tx_empty_s ? {DATA_W{1'b0}} : tx_mem_q[tx_rp_q[FIFO_AW-1:0]];
    assign bus.done      = done_q;
endmodule

// File: tb/tb_tea_io_mailbox.sv
// Self-checking bench for tea_io_mailbox: directed scenarios plus randomized host/CPU traffic
// checked every cycle against a queue-based reference model.
module tb_tea_io_mailbox;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tea_io_mailbox_if #(.DATA_W(8)) mb_if ();
    tea_io_mailbox #(.FIFO_AW(3), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(mb_if));

    int total = 0;
    int bad   = 0;
    byte unsigned rx_q[$];
    byte unsigned tx_q[$];
    bit m_unf, m_ovf, m_loop, m_done;
    bit rand_host;
    logic [7:0] last_rd;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_read(logic [4:0] a);
        case (a)
            5'h00:   return (rx_q.size() != 0) ? rx_q[0] : 8'h00;
            5'h02:   return {3'b000, m_loop, m_ovf, m_unf, (tx_q.size() == DEPTH), (rx_q.size() != 0)};
            5'h03:   return 8'(rx_q.size());
            default: return 8'h00;
        endcase
    endfunction

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic cycle(bit rd_c, bit wr_c);
        bit hpush, hpop, nd;
        int rx_pre, tx_pre;
        logic [4:0] a;
        logic [7:0] wd;
        if (rand_host) begin
            mb_if.s_valid = 1'($urandom_range(0, 1));
            mb_if.s_data  = 8'($urandom);
            mb_if.m_ready = 1'($urandom_range(0, 1));
        end
        #1;
        check_eq("s_ready", mb_if.s_ready, (rx_q.size() < DEPTH) && !m_loop);
        check_eq("m_valid", mb_if.m_valid, tx_q.size() != 0);
        check_eq("m_data", mb_if.m_data, (tx_q.size() != 0) ? tx_q[0] : 8'h00);
        check_eq("done", mb_if.done, m_done);
        check_eq("rddata", mb_if.io_rddata, mb_if.io_rd ? model_read(mb_if.io_addr) : 8'h00);
        if (mb_if.io_rd) last_rd = mb_if.io_rddata;
        a      = mb_if.io_addr;
        wd     = mb_if.io_wrdata;
        rx_pre = rx_q.size();
        tx_pre = tx_q.size();
        hpush  = mb_if.s_valid && (rx_pre < DEPTH) && !m_loop;
        hpop   = mb_if.m_ready && (tx_pre != 0);
        nd     = wr_c && (a == 5'h04) && wd[0];
        if (hpop) void'(tx_q.pop_front());
        if (rd_c && a == 5'h00) begin
            if (rx_pre != 0) void'(rx_q.pop_front());
            else m_unf = 1'b1;
        end
        if (hpush) rx_q.push_back(mb_if.s_data);
        if (wr_c) begin
            if (a == 5'h01) begin
                if (m_loop) begin
                    if (hpush || rx_pre == DEPTH) m_ovf = 1'b1;
                    else rx_q.push_back(wd);
                end else begin
                    if (tx_pre == DEPTH) m_ovf = 1'b1;
                    else tx_q.push_back(wd);
                end
            end else if (a == 5'h02) begin
                if (wd[2]) m_unf = 1'b0;
                if (wd[3]) m_ovf = 1'b0;
            end else if (a == 5'h04) begin
`ifdef TEA_MAILBOX_LOOPBACK_EN
                m_loop = wd[1];
`endif
            end
        end
        @(posedge clk);
        #1;
        m_done = nd;
    endtask

    task automatic cpu_access(bit is_rd, logic [4:0] a, logic [7:0] wd, bit push_on_commit, logic [7:0] pd);
        mb_if.io_addr   = a;
        mb_if.io_wrdata = wd;
        if (is_rd) mb_if.io_rd = 1'b1;
        else mb_if.io_wr = 1'b1;
        cycle(1'b0, 1'b0);
        if (push_on_commit) begin
            mb_if.s_valid = 1'b1;
            mb_if.s_data  = pd;
        end
        cycle(is_rd, !is_rd);
        mb_if.io_rd = 1'b0;
        mb_if.io_wr = 1'b0;
        if (push_on_commit) mb_if.s_valid = 1'b0;
        cycle(1'b0, 1'b0);
    endtask

    task automatic cpu_read(logic [4:0] a, output logic [7:0] v);
        cpu_access(1'b1, a, 8'h00, 1'b0, 8'h00);
        v = last_rd;
    endtask

    task automatic host_push(logic [7:0] d);
        mb_if.s_valid = 1'b1;
        mb_if.s_data  = d;
        cycle(1'b0, 1'b0);
        mb_if.s_valid = 1'b0;
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_s_ready", mb_if.s_ready, 1'b1);
        check_eq("rst_m_valid", mb_if.m_valid, 1'b0);
        mb_if.io_addr = 5'h03;
        mb_if.io_rd   = 1'b1;
        #1;
        check_eq("rst_rx_count", mb_if.io_rddata, 8'h00);
        mb_if.io_rd = 1'b0;
        rx_q.delete();
        tx_q.delete();
        m_unf = 1'b0; m_ovf = 1'b0; m_loop = 1'b0; m_done = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] plan [4];
        plan[0] = 8'h9E; plan[1] = 8'h37; plan[2] = 8'h79; plan[3] = 8'hB9;
        rst = 1'b1;
        rand_host = 1'b0;
        m_unf = 1'b0; m_ovf = 1'b0; m_loop = 1'b0; m_done = 1'b0;
        mb_if.io_addr = 5'h00; mb_if.io_rd = 1'b0; mb_if.io_wr = 1'b0; mb_if.io_wrdata = 8'h00;
        mb_if.s_valid = 1'b0; mb_if.s_data = 8'h00; mb_if.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_s_ready", mb_if.s_ready, 1'b1);
        check_eq("reset_m_valid", mb_if.m_valid, 1'b0);
        check_eq("reset_m_data", mb_if.m_data, 8'h00);
        check_eq("reset_done", mb_if.done, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 1'b0);

        for (int i = 0; i < 4; i++) host_push(plan[i]);
        cpu_read(5'h03, v); check_eq("rx_count_4", v, 8'h04);
        for (int i = 0; i < 4; i++) begin
            cpu_read(5'h00, v); check_eq("rx_order", v, plan[i]);
        end
        cpu_read(5'h02, v); check_eq("status_clean", v, 8'h00);

        cpu_read(5'h00, v); check_eq("rx_empty_read", v, 8'h00);
        cpu_read(5'h02, v); check_eq("status_unf", v, 8'h04);
        cpu_access(1'b0, 5'h02, 8'h04, 1'b0, 8'h00);
        cpu_read(5'h02, v); check_eq("status_unf_clr", v, 8'h00);

        for (int i = 1; i <= 9; i++) cpu_access(1'b0, 5'h01, 8'(i), 1'b0, 8'h00);
        check_eq("tx_m_valid", mb_if.m_valid, 1'b1);
        cpu_read(5'h02, v); check_eq("status_ovf_full", v, 8'h0A);
        mb_if.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_eq("tx_drain", mb_if.m_data, 8'(i));
            cycle(1'b0, 1'b0);
        end
        check_eq("tx_drained", mb_if.m_valid, 1'b0);
        mb_if.m_ready = 1'b0;
        cpu_access(1'b0, 5'h02, 8'h08, 1'b0, 8'h00);

        host_push(8'hA1); host_push(8'hA2); host_push(8'hA3);
        cpu_access(1'b1, 5'h00, 8'h00, 1'b1, 8'hA4);
        check_eq("simul_pop", last_rd, 8'hA1);
        cpu_read(5'h03, v); check_eq("simul_count", v, 8'h03);
        mb_if.io_addr = 5'h00;
        mb_if.io_rd   = 1'b1;
        cycle(1'b0, 1'b0);
        mb_if.io_rd   = 1'b0;
        cycle(1'b0, 1'b0);
        cpu_read(5'h03, v); check_eq("pulse_no_pop", v, 8'h03);
        cpu_read(5'h00, v); check_eq("order_a2", v, 8'hA2);
        cpu_read(5'h00, v); check_eq("order_a3", v, 8'hA3);
        cpu_read(5'h00, v); check_eq("order_a4", v, 8'hA4);

        mb_if.io_addr = 5'h04; mb_if.io_wrdata = 8'h01; mb_if.io_wr = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check_eq("done_high", mb_if.done, 1'b1);
        mb_if.io_wr = 1'b0;
        cycle(1'b0, 1'b0);
        check_eq("done_low", mb_if.done, 1'b0);

        for (int i = 0; i < 5; i++) host_push(8'(8'h50 + i));
        cpu_access(1'b0, 5'h01, 8'h77, 1'b0, 8'h00);
        mid_reset();
        cycle(1'b0, 1'b0);
        cpu_read(5'h03, v); check_eq("post_rst_count", v, 8'h00);

`ifdef TEA_MAILBOX_LOOPBACK_EN
        cpu_access(1'b0, 5'h04, 8'h02, 1'b0, 8'h00);
        cpu_access(1'b0, 5'h01, 8'hC6, 1'b0, 8'h00);
        check_eq("lb_m_valid", mb_if.m_valid, 1'b0);
        check_eq("lb_s_ready", mb_if.s_ready, 1'b0);
        cpu_read(5'h00, v); check_eq("lb_rx", v, 8'hC6);
        cpu_access(1'b0, 5'h04, 8'h00, 1'b0, 8'h00);
`endif

        rand_host = 1'b1;
        repeat (300) begin
            case ($urandom_range(0, 3))
                0: cycle(1'b0, 1'b0);
                1: cpu_read(5'($urandom_range(0, 5)), v);
                2: cpu_access(1'b0, 5'h01, 8'($urandom), 1'b0, 8'h00);
                default: cpu_access(1'b0, ($urandom_range(0, 1) != 0) ? 5'h02 : 5'h04,
                                    8'($urandom), 1'b0, 8'h00);
            endcase
        end
        rand_host = 1'b0;
        mb_if.s_valid = 1'b0;
        mb_if.m_ready = 1'b0;
        cycle(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
